// File: rtl/sseg_scan_driver.sv
// Scanned N-digit common-anode hex display driver with double-buffered loads.
// Optional PWM dimming when SSEG_BRIGHTNESS_EN is defined.
`timescale 1ns/1ps
module sseg_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int GUARD_CYCLES = 200,
   parameter int BRIGHT_W     = 4
) (
   input  logic                      clock_i,
   input  logic                      reset_i,
   input  logic [4*NUM_DIGITS-1:0]   value_i,
   input  logic [NUM_DIGITS-1:0]     dp_i,
   input  logic [NUM_DIGITS-1:0]     blank_i,
   input  logic                      lz_en_i,
   input  logic                      load_i,
`ifdef SSEG_BRIGHTNESS_EN
   input  logic [BRIGHT_W-1:0]       brightness_i,
`endif
   output logic [NUM_DIGITS-1:0]     an_n_o,
   output logic [7:0]                seg_n_o,
   output logic                      frame_o
);

   localparam int SLOT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
   localparam logic [SLOT_W-1:0] GUARD_END = SLOT_W'(GUARD_CYCLES);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   logic [SLOT_W-1:0]       slot_cnt_q, slot_cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    pending_q, pending_d;
   logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d;
   logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
   logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
   logic                    sh_lz_q, sh_lz_d;
   logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d;
   logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
   logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
   logic                    act_lz_q, act_lz_d;
   logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
   logic [7:0]              seg_n_q, seg_n_d;
   logic                    frame_q, frame_d;

   logic                    slot_term;
   logic                    wrap;
   logic                    guard;
   logic                    pwm_on;
   logic                    zero_above;
   logic [NUM_DIGITS-1:0]   sup;
   logic [3:0]              nib;
   logic [6:0]              font;
   logic                    dark;

`ifdef SSEG_BRIGHTNESS_EN
   logic [BRIGHT_W-1:0]     pwm_cnt_q, pwm_cnt_d;

   always_comb begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      pwm_on    = (pwm_cnt_q < brightness_i) || (&brightness_i);
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) pwm_cnt_q <= '0;
      else         pwm_cnt_q <= pwm_cnt_d;
   end
`else
   always_comb pwm_on = 1'b1;
`endif

   always_comb begin
      slot_term  = (slot_cnt_q == SLOT_LAST);
      wrap       = slot_term && (idx_q == IDX_LAST);
      slot_cnt_d = slot_term ? '0 : slot_cnt_q + 1'b1;
      idx_d      = idx_q;
      if (slot_term) idx_d = wrap ? '0 : idx_q + 1'b1;
      frame_d    = wrap;

      sh_val_d   = sh_val_q;
      sh_dp_d    = sh_dp_q;
      sh_blank_d = sh_blank_q;
      sh_lz_d    = sh_lz_q;
      if (load_i) begin
         sh_val_d   = value_i;
         sh_dp_d    = dp_i;
         sh_blank_d = blank_i;
         sh_lz_d    = lz_en_i;
      end

      // A load on the copy edge lands in shadow and waits a whole frame.
      pending_d = pending_q;
      if (wrap)   pending_d = 1'b0;
      if (load_i) pending_d = 1'b1;

      act_val_d   = act_val_q;
      act_dp_d    = act_dp_q;
      act_blank_d = act_blank_q;
      act_lz_d    = act_lz_q;
      if (wrap && pending_q) begin
         act_val_d   = sh_val_q;
         act_dp_d    = sh_dp_q;
         act_blank_d = sh_blank_q;
         act_lz_d    = sh_lz_q;
      end
   end

   // Suppress a digit when it and everything above is zero with no DP lit.
   always_comb begin
      zero_above = 1'b1;
      sup        = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above & (act_val_q[4*i +: 4] == 4'h0) & ~act_dp_q[i];
         sup[i]     = zero_above & act_lz_q & (i != 0);
      end
   end

   always_comb begin
      nib = act_val_q[{idx_q, 2'b00} +: 4];
      unique case (nib)
         4'h0: font = 7'h3F;
         4'h1: font = 7'h06;
         4'h2: font = 7'h5B;
         4'h3: font = 7'h4F;
         4'h4: font = 7'h66;
         4'h5: font = 7'h6D;
         4'h6: font = 7'h7D;
         4'h7: font = 7'h07;
         4'h8: font = 7'h7F;
         4'h9: font = 7'h6F;
         4'hA: font = 7'h77;
         4'hB: font = 7'h7C;
         4'hC: font = 7'h39;
         4'hD: font = 7'h5E;
         4'hE: font = 7'h79;
         4'hF: font = 7'h71;
         default: font = 7'h00;
      endcase
      guard  = (slot_cnt_q < GUARD_END);
      dark   = act_blank_q[idx_q] | sup[idx_q];
      an_n_d = '1;
      if (!guard && pwm_on) an_n_d[idx_q] = 1'b0;
      seg_n_d = (guard || dark) ? 8'hFF : ~{act_dp_q[idx_q], font};
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         slot_cnt_q  <= '0;
         idx_q       <= '0;
         pending_q   <= 1'b0;
         sh_val_q    <= '0;
         sh_dp_q     <= '0;
         sh_blank_q  <= '0;
         sh_lz_q     <= 1'b0;
         act_val_q   <= '0;
         act_dp_q    <= '0;
         act_blank_q <= '0;
         act_lz_q    <= 1'b0;
         an_n_q      <= '1;
         seg_n_q     <= 8'hFF;
         frame_q     <= 1'b0;
      end else begin
         slot_cnt_q  <= slot_cnt_d;
         idx_q       <= idx_d;
         pending_q   <= pending_d;
         sh_val_q    <= sh_val_d;
         sh_dp_q     <= sh_dp_d;
         sh_blank_q  <= sh_blank_d;
         sh_lz_q     <= sh_lz_d;
         act_val_q   <= act_val_d;
         act_dp_q    <= act_dp_d;
         act_blank_q <= act_blank_d;
         act_lz_q    <= act_lz_d;
         an_n_q      <= an_n_d;
         seg_n_q     <= seg_n_d;
         frame_q     <= frame_d;
      end
   end

   assign an_n_o  = an_n_q;
   assign seg_n_o = seg_n_q;
   assign frame_o = frame_q;

endmodule
